// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART TX arbiter.
//   arb_state_e     - arbiter FSM state encoding
//   DEF_NUM_REQ     - default number of requesters
//   DEF_DATA_WIDTH  - default byte width
//   idx_w()         - width of an index into an n-entry vector (minimum 1)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
// Scans req starting one past the last winner, wrapping modulo NUM_REQ, and
// returns the first set bit.
// Ports:
//   req    in  [NUM_REQ-1:0]  pending requests
//   last   in  [IW-1:0]       index of the previous winner
//   valid  out                any request pending
//   winner out [IW-1:0]       index of the selected requester
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IW     = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      winner
);

  int idx;

  // Scan from the farthest offset down to the nearest so the closest set bit
  // after last is the one that sticks.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among
// NUM_REQ requesters. One byte is captured per grant, launched with a single
// TX_DATA_VALID pulse, and the UART Busy flag is tracked through the whole
// frame before the next grant.
//
// Optional feature: define ARB_TIMEOUT_EN to add a TIMEOUT_CYC watchdog on
// Busy rising after a launch; when it expires TO_ERR pulses, the byte is
// dropped and the arbiter returns to IDLE. Without it TO_ERR is tied 0 and the
// arbiter waits for Busy indefinitely.
//
// Ports:
//   CLK           in   UART TX clock
//   RST           in   asynchronous active-high reset
//   REQ           in   per-requester level request, held until ACK
//   REQ_DATA      in   packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ACK           out  one-hot one-cycle pulse, byte captured
//   GNT_ID        out  index of the last granted requester
//   TX_P_DATA     out  byte to UART P_DATA, held until the next grant
//   TX_DATA_VALID out  one-cycle launch strobe
//   TX_Busy       in   UART Busy
//   ARB_Busy      out  high whenever the FSM is not in IDLE
//   TO_ERR        out  one-cycle Busy-timeout pulse
//
// State | meaning
// IDLE      | waiting for a request while the UART is idle
// LAUNCH    | TX_DATA_VALID and ACK asserted for exactly one cycle
// WAIT_BUSY | waiting for the UART to raise Busy
// WAIT_DONE | frame in progress, waiting for Busy to fall
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            ACK,
  output logic [idx_w(NUM_REQ)-1:0]     GNT_ID,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_DATA_VALID,
  input  logic                          TX_Busy,
  output logic                          ARB_Busy,
  output logic                          TO_ERR
);

  localparam int IW = idx_w(NUM_REQ);

  arb_state_e            state_q;
  logic [NUM_REQ-1:0]    ack_q;
  logic [IW-1:0]         gnt_q;
  logic [IW-1:0]         last_q;
  logic [DATA_WIDTH-1:0] pdata_q;
  logic                  dv_q;
  logic                  arb_busy_q;

  logic                  pick_valid;
  logic [IW-1:0]         pick_winner;
  logic [DATA_WIDTH-1:0] pick_byte_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] to_cnt_q;
  logic       to_err_q;
`endif

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (REQ),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign pick_byte_d = REQ_DATA[int'(pick_winner)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      gnt_q      <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      pdata_q    <= '0;
      dv_q       <= 1'b0;
      arb_busy_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q   <= '0;
      to_err_q   <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; only the grant edge raises them.
      ack_q <= '0;
      dv_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // A Busy seen here belongs to a frame we did not launch; hold off.
          if (pick_valid && !TX_Busy) begin
            pdata_q             <= pick_byte_d;
            gnt_q               <= pick_winner;
            last_q              <= pick_winner;
            ack_q[pick_winner]  <= 1'b1;
            dv_q                <= 1'b1;
            arb_busy_q          <= 1'b1;
            state_q             <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef ARB_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (TX_Busy) begin
            state_q <= WAIT_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            // Byte is abandoned; last_q already points at it so rotation moves on.
            to_err_q   <= 1'b1;
            arb_busy_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
`endif
        end
        WAIT_DONE: begin
          if (!TX_Busy) begin
            arb_busy_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          arb_busy_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign ACK           = ack_q;
  assign GNT_ID        = gnt_q;
  assign TX_P_DATA     = pdata_q;
  assign TX_DATA_VALID = dv_q;
  assign ARB_Busy      = arb_busy_q;
`ifdef ARB_TIMEOUT_EN
  assign TO_ERR        = to_err_q;
`else
  assign TO_ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic [1:0]  gnt;
  logic [7:0]  pdata;
  logic        dv;
  logic        tx_busy = 1'b0;
  logic        arb_busy;
  logic        to_err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .CLK           (clk),
    .RST           (rst),
    .REQ           (req),
    .REQ_DATA      (req_data),
    .ACK           (ack),
    .GNT_ID        (gnt),
    .TX_P_DATA     (pdata),
    .TX_DATA_VALID (dv),
    .TX_Busy       (tx_busy),
    .ARB_Busy      (arb_busy),
    .TO_ERR        (to_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'h0);
    chk({tag, "_dv"}, 32'(dv), 32'h0);
    chk({tag, "_arb_busy"}, 32'(arb_busy), 32'h0);
    chk({tag, "_to_err"}, 32'(to_err), 32'h0);
    chk({tag, "_pdata"}, 32'(pdata), 32'h0);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
  endtask

  // Entered on a negedge with the FSM in IDLE and req already driven. Checks the
  // launch cycle, then models a UART frame: Busy rises one cycle after
  // DATA_VALID and is held blen cycles. Returns on the negedge after the FSM is
  // back in IDLE.
  task automatic serve(input string tag, input int id, input logic [7:0] b,
                       input logic [3:0] nreq, input int blen);
    @(negedge clk);
    chk({tag, "_dv"}, 32'(dv), 32'h1);
    chk({tag, "_ack"}, 32'(ack), 32'(1) << id);
    chk({tag, "_gnt"}, 32'(gnt), 32'(id));
    chk({tag, "_pdata"}, 32'(pdata), 32'(b));
    chk({tag, "_arb_busy"}, 32'(arb_busy), 32'h1);
    req = nreq;
    @(negedge clk);
    chk({tag, "_dv_off"}, 32'(dv), 32'h0);
    chk({tag, "_ack_off"}, 32'(ack), 32'h0);
    tx_busy = 1'b1;
    repeat (blen) @(negedge clk);
    chk({tag, "_busy_hold"}, 32'(arb_busy), 32'h1);
    tx_busy = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(arb_busy), 32'h0);
    chk({tag, "_pdata_hold"}, 32'(pdata), 32'(b));
  endtask

  initial begin
    // Reset state
    #2;
    chk_reset_outs("rst");
    @(negedge clk);
    rst = 1'b0;

    // Single byte from requester 0, 10-cycle frame
    req_data = 32'h0000_00A5;
    req = 4'b0001;
    serve("single", 0, 8'hA5, 4'b0000, 10);

    // Full rotation from a fresh pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_data = 32'h1312_1110;
    req = 4'b1111;
    serve("rr0", 0, 8'h10, 4'b1111, 3);
    serve("rr1", 1, 8'h11, 4'b1111, 3);
    serve("rr2", 2, 8'h12, 4'b1111, 3);
    serve("rr3", 3, 8'h13, 4'b1111, 3);
    serve("rr4", 0, 8'h10, 4'b0000, 3);

    // Last grant 2, then 0 and 1 competing: wraps to 0 first
    req_data = 32'h4433_2211;
    req = 4'b0100;
    serve("wr2", 2, 8'h33, 4'b0011, 2);
    serve("wr0", 0, 8'h11, 4'b0010, 2);
    serve("wr1", 1, 8'h22, 4'b0000, 2);

    // External Busy in IDLE blocks grants; a request dropped meanwhile is lost
    tx_busy = 1'b1;
    req = 4'b0100;
    repeat (2) begin
      @(negedge clk);
      chk("ext_busy_ack2", 32'(ack), 32'h0);
    end
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0001;
    repeat (3) begin
      @(negedge clk);
      chk("ext_busy_ack0", 32'(ack), 32'h0);
      chk("ext_busy_dv", 32'(dv), 32'h0);
      chk("ext_busy_arb", 32'(arb_busy), 32'h0);
    end
    tx_busy = 1'b0;
    serve("ext_rel", 0, 8'h11, 4'b0000, 2);

    // Busy never rises after launch
    req = 4'b0001;
    @(negedge clk);
    chk("to_dv", 32'(dv), 32'h1);
    chk("to_ack", 32'(ack), 32'h1);
    req = 4'b0000;
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("to_quiet", 32'(to_err), 32'h0);
    end
    @(negedge clk);
    chk("to_pulse", 32'(to_err), 32'h1);
    chk("to_idle", 32'(arb_busy), 32'h0);
    req = 4'b0010;
    serve("to_next", 1, 8'h22, 4'b0000, 2);
    chk("to_clear", 32'(to_err), 32'h0);
`else
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("nto_quiet", 32'(to_err), 32'h0);
    end
    chk("nto_wait", 32'(arb_busy), 32'h1);
    tx_busy = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("nto_idle", 32'(arb_busy), 32'h0);
    req = 4'b0010;
    serve("nto_next", 1, 8'h22, 4'b0000, 2);
`endif

    // Reset while a frame is in flight; pointer must restart at requester 0
    req_data = 32'h8A5A_6B7C;
    req = 4'b0100;
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_arb", 32'(arb_busy), 32'h1);
    chk("mid_pdata", 32'(pdata), 32'h5A);
    #2 rst = 1'b1;
    #1;
    chk_reset_outs("mid_rst");
    @(negedge clk);
    tx_busy = 1'b0;
    rst = 1'b0;
    req = 4'b1010;
    serve("post_rst", 1, 8'h6B, 4'b0000, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
